stream_ram: RTL and testbench
=============================

Name: stream_ram

Overview:
Parametrised single-clock RAM for puzzle input and scratch storage, generalising the byte-wide block RAM.
- Configurable data width and depth; byte-enable write port.
- Valid/ready read channel with selectable read latency and a response buffer, so consumers can back-pressure without losing data.
- Hardware clear engine that fills the array with a constant.
Sits between the input loader / solver datapaths and on-chip block RAM.

Parameters:
DATA_W, 8, word width in bits; must be a multiple of 8
DEPTH, 16384, number of words
ADDR_W, $clog2(DEPTH), address width (derived; do not override)
READ_LATENCY, 1, request-accept to earliest RspValid in cycles; legal values 1 or 2 (2 adds an output register after the array)
INIT_FILE, "common/mem.rom", hex image loaded at elaboration; empty string means no preload
CLEAR_VALUE, 0, word written by the clear engine

Ports:
Clk  in  1  clock
RstN  in  1  asynchronous active-low reset
WrEn  in  1  write strobe; takes effect only when WrReady=1
WrAddr  in  ADDR_W  write address
WrData  in  DATA_W  write data
WrBe  in  DATA_W/8  byte enables; bit i gates WrData[8i+7:8i]
WrReady  out  1  write accepted this cycle
ReqValid  in  1  read request valid
ReqAddr  in  ADDR_W  read address
ReqReady  out  1  read request accepted when ReqValid && ReqReady
RspValid  out  1  read response valid
RspData  out  DATA_W  read response data
RspReady  in  1  consumer accepts response
ClearStart  in  1  single-cycle pulse; starts a clear, ignored unless idle
Busy  out  1  clear in progress

Behaviour:
- Reset (asynchronous, RstN=0):
  - Clears FSM, counters, pipeline valids and the response buffer.
  - Memory contents are not reset.
  - Output values in reset: RspValid=0, RspData=0, Busy=0, WrReady=1, ReqReady=1.
- Reset mid-operation:
  - Aborts any clear; the array is left partially cleared.
  - Discards in-flight reads and buffered responses.
- FSM states and transitions:
  - IDLE -> CLEARING on ClearStart.
  - CLEARING -> IDLE on the cycle after address DEPTH-1 is written.
  - ClearStart while in CLEARING is ignored.
- CLEARING:
  - Engine writes CLEAR_VALUE to addresses 0..DEPTH-1, one word per cycle, full width.
  - Takes exactly DEPTH cycles. Busy=1 from the cycle after ClearStart through the last clear write.
  - WrReady=0 and ReqReady=0 throughout; writes presented in this state are dropped and never performed later.
  - Reads accepted before ClearStart still complete, with their pre-clear data.
- Writes:
  - Performed at the clock edge when WrEn && WrReady.
  - Only bytes with WrBe=1 change.
  - WrBe=0 performs no write.
- Reads:
  - The array is read at the accept edge.
  - Response data equals the memory state after every write accepted up to and including the accept cycle.
  - A read and a write to the same address in the same cycle return the merged new data (write-first, byte-granular forwarding).
  - Later writes never alter an accepted read.
- Response ordering and latency:
  - Responses are returned strictly in request order.
  - Latency is READ_LATENCY cycles when RspReady has been high.
  - Throughput is one read per cycle sustained.
- Flow control:
  - Response buffer depth is READ_LATENCY+1 entries.
  - ReqReady = !CLEARING && (in_flight + buffered) < READ_LATENCY+1. ReqReady is combinational from registered state only, never from ReqValid.
  - With RspReady low, no response is dropped or duplicated. RspValid/RspData hold stable until accepted.
- Simultaneous events:
  - A response accept and a new request accept in the same cycle update the occupancy count net zero.
  - ClearStart in the same cycle as an accepted read: the read is accepted and returns pre-clear data.
- Width rule: every address is below DEPTH. Addresses at or above DEPTH (non-power-of-two DEPTH) are undefined; the bench must not generate them.

Decomposition:
- AocPkg additions:
  - STREAM_RAM_DEPTH and STREAM_RAM_DATA_W constants.
  - A RamAddr_t typedef sized $clog2(STREAM_RAM_DEPTH).
  - An FSM state enum RamState_e {RAM_IDLE, RAM_CLEARING}.
- Sub-module ram_array_core:
  - Plain inferred block-RAM array with byte-enable write and a registered read.
  - Takes DATA_W, DEPTH and INIT_FILE.
  - Keeps the block_ram style attribute.
- stream_ram owns:
  - The clear FSM.
  - Write-mux between the user port and the clear engine.
  - Same-cycle forwarding.
  - Latency pipeline.
  - Occupancy counter.
  - Response FIFO.

Test Plan:
- Preload and latency: INIT_FILE word 5=0x3A, READ_LATENCY=1; request addr 5 with RspReady=1 -> RspValid and RspData=0x3A one cycle after accept. With READ_LATENCY=2 -> two cycles.
- Byte-enable write: DATA_W=32, write 0xAABBCCDD to addr 7 with WrBe=4'b0101 over 0x11223344 -> read returns 0x11BB33DD.
- Read-during-write forwarding: same cycle, write 0x55 to addr 9 and accept a read of addr 9 -> response 0x55. A read accepted one cycle before the write -> old value.
- Back-pressure: 10 back-to-back requests for addrs 0..9, RspReady low for 4 cycles mid-stream -> ReqReady drops once occupancy reaches READ_LATENCY+1; all 10 responses arrive in order, none lost or duplicated.
- Clear: DEPTH=16; ClearStart -> Busy high exactly 16 cycles, WrReady/ReqReady low for that span; a write during CLEARING is dropped; afterwards all 16 addresses read CLEAR_VALUE.
- Reset mid-clear: assert RstN=0 at clear cycle 6 -> outputs return to reset values immediately; addrs 0..5 cleared, addr 10 keeps its preload value; a new read is accepted the first cycle after reset release.

Source files
------------

// File: rtl/stream_ram_pkg.sv
// Shared constants and types for the streaming RAM block.
package stream_ram_pkg;

    localparam int unsigned STREAM_RAM_DEPTH  = 16384;
    localparam int unsigned STREAM_RAM_DATA_W = 8;

    typedef logic [$clog2(STREAM_RAM_DEPTH)-1:0] RamAddr_t;

    typedef enum logic {
        RAM_IDLE     = 1'b0,
        RAM_CLEARING = 1'b1
    } RamState_e;

endpackage

// File: rtl/stream_ram_array_core.sv
// Inferred block-RAM array: byte-enable write port, registered read-first read port.
module ram_array_core #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DEPTH     = 16,
    parameter string       INIT_FILE = "",
    localparam int unsigned ADDR_W   = $clog2(DEPTH),
    localparam int unsigned BE_W     = DATA_W / 8
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [BE_W-1:0]   be_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    (* ram_style = "block" *) logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Byte-gated write and registered read (returns pre-write contents).
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < int'(BE_W); b++) begin
                if (be_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
        if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/stream_ram.sv
// Streaming RAM: byte-enable writes, valid/ready reads with response buffer, clear engine.
module stream_ram
    import stream_ram_pkg::*;
#(
    parameter int unsigned       DATA_W       = STREAM_RAM_DATA_W,
    parameter int unsigned       DEPTH        = STREAM_RAM_DEPTH,
    parameter int unsigned       READ_LATENCY = 1,
    parameter string             INIT_FILE    = "common/mem.rom",
    parameter logic [DATA_W-1:0] CLEAR_VALUE  = '0,
    localparam int unsigned      ADDR_W       = $clog2(DEPTH),
    localparam int unsigned      BE_W         = DATA_W / 8
) (
    input  logic              Clk,
    input  logic              RstN,
    input  logic              WrEn,
    input  logic [ADDR_W-1:0] WrAddr,
    input  logic [DATA_W-1:0] WrData,
    input  logic [BE_W-1:0]   WrBe,
    output logic              WrReady,
    input  logic              ReqValid,
    input  logic [ADDR_W-1:0] ReqAddr,
    output logic              ReqReady,
    output logic              RspValid,
    output logic [DATA_W-1:0] RspData,
    input  logic              RspReady,
    input  logic              ClearStart,
    output logic              Busy
);

    localparam int unsigned BUF_D = READ_LATENCY + 1;
    localparam int unsigned OCC_W = $clog2(BUF_D + 1);
    localparam int unsigned PTR_W = (BUF_D > 1) ? $clog2(BUF_D) : 1;

    RamState_e         state_q;
    logic [ADDR_W-1:0] clr_addr_q;
    logic              clearing;

    logic              wr_fire, req_fire, rsp_fire;
    logic              core_we;
    logic [ADDR_W-1:0] core_waddr;
    logic [DATA_W-1:0] core_wdata;
    logic [BE_W-1:0]   core_be;
    logic [DATA_W-1:0] core_rdata;

    logic [BE_W-1:0]   fwd_be_d, fwd_be_q;
    logic [DATA_W-1:0] fwd_data_q;
    logic              v1_q;
    logic [DATA_W-1:0] merged1;
    logic              out_v;
    logic [DATA_W-1:0] out_d;

    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [DATA_W-1:0] buf_q [BUF_D];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [OCC_W-1:0]  cnt_q, cnt_d;
    logic              buf_empty, push, pop;

    assign clearing = (state_q == RAM_CLEARING);
    assign Busy     = clearing;
    assign WrReady  = !clearing;
    assign ReqReady = !clearing && (occ_q < OCC_W'(BUF_D));
    assign wr_fire  = WrEn && WrReady;
    assign req_fire = ReqValid && ReqReady;

    // Clear FSM: sweeps every address once, one word per cycle.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state_q    <= RAM_IDLE;
            clr_addr_q <= '0;
        end else begin
            case (state_q)
                RAM_IDLE: begin
                    if (ClearStart) begin
                        state_q    <= RAM_CLEARING;
                        clr_addr_q <= '0;
                    end
                end
                RAM_CLEARING: begin
                    if (clr_addr_q == ADDR_W'(DEPTH - 1)) state_q <= RAM_IDLE;
                    clr_addr_q <= clr_addr_q + ADDR_W'(1);
                end
                default: state_q <= RAM_IDLE;
            endcase
        end
    end

    // Array write port: clear engine owns it while clearing, user port otherwise.
    always_comb begin
        core_we    = wr_fire;
        core_waddr = WrAddr;
        core_wdata = WrData;
        core_be    = WrBe;
        if (clearing) begin
            core_we    = 1'b1;
            core_waddr = clr_addr_q;
            core_wdata = CLEAR_VALUE;
            core_be    = '1;
        end
    end

    ram_array_core #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .INIT_FILE (INIT_FILE)
    ) u_core (
        .clk_i   (Clk),
        .we_i    (core_we),
        .waddr_i (core_waddr),
        .wdata_i (core_wdata),
        .be_i    (core_be),
        .re_i    (req_fire),
        .raddr_i (ReqAddr),
        .rdata_o (core_rdata)
    );

    // Bytes written to the read address in the accept cycle override the array's old data.
    always_comb begin
        fwd_be_d = '0;
        if (wr_fire && (WrAddr == ReqAddr)) fwd_be_d = WrBe;
    end

    // First pipeline stage: valid plus captured forwarding info.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            v1_q       <= 1'b0;
            fwd_be_q   <= '0;
            fwd_data_q <= '0;
        end else begin
            v1_q <= req_fire;
            if (req_fire) begin
                fwd_be_q   <= fwd_be_d;
                fwd_data_q <= WrData;
            end
        end
    end

    // Byte-granular merge of forwarded write data over array read data.
    always_comb begin
        merged1 = core_rdata;
        for (int b = 0; b < int'(BE_W); b++) begin
            if (fwd_be_q[b]) merged1[8*b +: 8] = fwd_data_q[8*b +: 8];
        end
    end

    generate
        if (READ_LATENCY >= 2) begin : g_lat2
            logic              v2_q;
            logic [DATA_W-1:0] d2_q;

            // Extra output register after the array.
            always_ff @(posedge Clk or negedge RstN) begin
                if (!RstN) begin
                    v2_q <= 1'b0;
                    d2_q <= '0;
                end else begin
                    v2_q <= v1_q;
                    if (v1_q) d2_q <= merged1;
                end
            end

            assign out_v = v2_q;
            assign out_d = d2_q;
        end else begin : g_lat1
            assign out_v = v1_q;
            assign out_d = merged1;
        end
    endgenerate

    // Buffer head has priority; pipeline output bypasses only when the buffer is empty.
    assign buf_empty = (cnt_q == '0);
    assign push      = out_v && !(buf_empty && RspReady);
    assign pop       = !buf_empty && RspReady;
    assign RspValid  = !buf_empty || out_v;
    assign rsp_fire  = RspValid && RspReady;

    // Response data mux; zero when nothing is presented.
    always_comb begin
        RspData = '0;
        if (!buf_empty) RspData = buf_q[rd_ptr_q];
        else if (out_v) RspData = out_d;
    end

    // Occupancy and buffer count next-state.
    always_comb begin
        occ_d = occ_q + OCC_W'(req_fire) - OCC_W'(rsp_fire);
        cnt_d = cnt_q + OCC_W'(push) - OCC_W'(pop);
    end

    // Occupancy counter and response buffer pointers.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            occ_q    <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            occ_q <= occ_d;
            cnt_q <= cnt_d;
            if (push) wr_ptr_q <= (wr_ptr_q == PTR_W'(BUF_D - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= (rd_ptr_q == PTR_W'(BUF_D - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
    end

    // Response buffer storage.
    always_ff @(posedge Clk) begin
        if (push) buf_q[wr_ptr_q] <= out_d;
    end

endmodule

// File: tb/tb_stream_ram.sv
// Randomised scoreboard bench for stream_ram (32-bit words, 16 deep, two-cycle read latency).
module tb_stream_ram;

    localparam int unsigned DW  = 32;
    localparam int unsigned DEP = 16;
    localparam int unsigned RL  = 2;
    localparam int unsigned AW  = 4;
    localparam int unsigned BW  = 4;
    localparam logic [DW-1:0] CV = 32'h5A5A_A5A5;

    logic          Clk = 1'b0;
    logic          RstN = 1'b0;
    logic          WrEn = 1'b0;
    logic [AW-1:0] WrAddr = '0;
    logic [DW-1:0] WrData = '0;
    logic [BW-1:0] WrBe = '0;
    logic          WrReady;
    logic          ReqValid = 1'b0;
    logic [AW-1:0] ReqAddr = '0;
    logic          ReqReady;
    logic          RspValid;
    logic [DW-1:0] RspData;
    logic          RspReady = 1'b0;
    logic          ClearStart = 1'b0;
    logic          Busy;

    stream_ram #(
        .DATA_W       (DW),
        .DEPTH        (DEP),
        .READ_LATENCY (RL),
        .INIT_FILE    (""),
        .CLEAR_VALUE  (CV)
    ) dut (
        .Clk        (Clk),
        .RstN       (RstN),
        .WrEn       (WrEn),
        .WrAddr     (WrAddr),
        .WrData     (WrData),
        .WrBe       (WrBe),
        .WrReady    (WrReady),
        .ReqValid   (ReqValid),
        .ReqAddr    (ReqAddr),
        .ReqReady   (ReqReady),
        .RspValid   (RspValid),
        .RspData    (RspData),
        .RspReady   (RspReady),
        .ClearStart (ClearStart),
        .Busy       (Busy)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] mem_m [DEP];
    int            cyc = 0;
    int            n_chk = 0;
    int            n_pass = 0;
    int            clr_left = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    endtask

    // Monitor: the oldest outstanding read must be presented once its latency has elapsed.
    always @(negedge Clk) begin
        if (RstN) begin
            logic exp_v;
            exp_v = (exp_q.size() != 0) && (exp_q[0].due <= cyc);
            check("rsp_valid", DW'(RspValid), DW'(exp_v));
            if (exp_v) begin
                check("rsp_data", RspData, exp_q[0].data);
                if (RspReady) void'(exp_q.pop_front());
            end
        end
    end

    // One clock cycle of stimulus; the model decides acceptance from its own state.
    task automatic step(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic [BW-1:0] be, input logic rv, input logic [AW-1:0] ra,
                        input logic rr, input logic cs, output logic rd_acc);
        logic exp_wr, exp_rq;
        WrEn = we; WrAddr = wa; WrData = wd; WrBe = be;
        ReqValid = rv; ReqAddr = ra; RspReady = rr; ClearStart = cs;
        exp_wr = (clr_left == 0);
        exp_rq = (clr_left == 0) && (exp_q.size() < int'(RL) + 1);
        check("wr_ready", DW'(WrReady), DW'(exp_wr));
        check("req_ready", DW'(ReqReady), DW'(exp_rq));
        check("busy", DW'(Busy), DW'(clr_left != 0));
        if (we && exp_wr) begin
            for (int b = 0; b < int'(BW); b++)
                if (be[b]) mem_m[wa][8*b +: 8] = wd[8*b +: 8];
        end
        rd_acc = rv && exp_rq;
        if (rd_acc) exp_q.push_back('{data: mem_m[ra], due: cyc + int'(RL)});
        if (clr_left != 0) begin
            mem_m[int'(DEP) - clr_left] = CV;
            clr_left--;
        end else if (cs) begin
            clr_left = int'(DEP);
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, 1'b0, '0, 1'b1, 1'b0, acc);
    endtask

    task automatic read_all();
        logic acc;
        for (int a = 0; a < int'(DEP); a++) begin
            acc = 1'b0;
            for (int t = 0; t < 20 && !acc; t++)
                step(1'b0, '0, '0, '0, 1'b1, AW'(a), 1'b1, 1'b0, acc);
        end
    endtask

    task automatic do_reset();
        RstN = 1'b0;
        #1;
        check("rst_rsp_valid", DW'(RspValid), '0);
        check("rst_rsp_data", RspData, '0);
        check("rst_busy", DW'(Busy), '0);
        check("rst_wr_ready", DW'(WrReady), DW'(1));
        check("rst_req_ready", DW'(ReqReady), DW'(1));
        exp_q.delete();
        clr_left = 0;
        WrEn = 1'b0; ReqValid = 1'b0; ClearStart = 1'b0; RspReady = 1'b0;
        @(posedge Clk);
        @(posedge Clk);
        #1;
        RstN = 1'b1;
    endtask

    task automatic random_phase(input int n, input int clr_pct);
        logic acc;
        for (int i = 0; i < n; i++) begin
            step(($urandom % 2) == 0, AW'($urandom), $urandom, BW'($urandom),
                 ($urandom % 10) < 6, AW'($urandom), ($urandom % 4) != 0,
                 ($urandom % 100) < clr_pct, acc);
        end
    endtask

    initial begin
        logic acc;
        int   n;
        do_reset();

        // Preload every word through the write port.
        for (int i = 0; i < int'(DEP); i++) begin
            logic [DW-1:0] d;
            d = (i == 5) ? 32'h0000_003A : (i == 7) ? 32'h1122_3344 :
                (i == 10) ? 32'hCAFE_F00D : $urandom;
            step(1'b1, AW'(i), d, '1, 1'b0, '0, 1'b1, 1'b0, acc);
        end
        idle(2);

        // Preloaded word and exact latency.
        step(1'b0, '0, '0, '0, 1'b1, AW'(5), 1'b1, 1'b0, acc);
        idle(4);

        // Byte-enable merge.
        step(1'b1, AW'(7), 32'hAABB_CCDD, 4'b0101, 1'b0, '0, 1'b1, 1'b0, acc);
        step(1'b0, '0, '0, '0, 1'b1, AW'(7), 1'b1, 1'b0, acc);
        idle(4);

        // Same-cycle forwarding, then a read one cycle ahead of a write.
        step(1'b1, AW'(9), 32'h0000_0055, '1, 1'b1, AW'(9), 1'b1, 1'b0, acc);
        step(1'b0, '0, '0, '0, 1'b1, AW'(9), 1'b1, 1'b0, acc);
        step(1'b1, AW'(9), 32'h0000_0066, '1, 1'b0, '0, 1'b1, 1'b0, acc);
        step(1'b1, AW'(9), 32'h7700_0000, 4'b1000, 1'b1, AW'(9), 1'b1, 1'b0, acc);
        idle(4);

        // Back-to-back reads of 0..9 with a four-cycle consumer stall.
        n = 0;
        for (int c = 0; c < 100 && n < 10; c++) begin
            step(1'b0, '0, '0, '0, 1'b1, AW'(n), !(c >= 3 && c < 7), 1'b0, acc);
            if (acc) n++;
        end
        idle(6);

        random_phase(300, 0);
        idle(6);

        // Clear with a read accepted in the ClearStart cycle and dropped traffic while busy.
        step(1'b1, AW'(3), 32'h0BAD_F00D, '1, 1'b1, AW'(3), 1'b1, 1'b1, acc);
        for (int i = 0; i < int'(DEP); i++)
            step(1'b1, AW'(i), $urandom, '1, 1'b1, AW'(i), 1'b1, ($urandom % 2) == 0, acc);
        read_all();
        idle(6);

        random_phase(400, 3);
        for (int i = 0; i < 40 && clr_left != 0; i++) idle(1);
        idle(6);

        // Reset six cycles into a clear.
        step(1'b1, AW'(10), 32'hCAFE_F00D, '1, 1'b0, '0, 1'b1, 1'b0, acc);
        step(1'b0, '0, '0, '0, 1'b1, AW'(4), 1'b1, 1'b1, acc);
        idle(6);
        do_reset();
        read_all();
        idle(8);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
